dm_bist_seq: RTL and testbench

Built-in self-test sequencer that sits directly upstream of the data memory RAM_B and feeds it.
- On start: writes a selected pattern to every word address, reads every word back, compares it against the regenerated expected value, and reports pass/fail and error statistics.
- Provides a 32-bit display word for DISPLAY, so a board run shows the result on the seven-segment digits.

---
 rtl/dm_bist_seq_if.sv | 30 +++
 rtl/dm_bist_seq.sv | 162 ++++++++++++++++
 tb/tb_dm_bist_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dm_bist_seq_if.sv
// RAM_B port bundle between the BIST sequencer (master) and the data memory (slave).
// Latency: none, wires only; the memory returns mem_rdata one cycle after mem_addr.
// Backpressure: none, the memory accepts one access per cycle unconditionally.
//   mem_we    : write enable, sequencer -> RAM
//   mem_addr  : word address, sequencer -> RAM
//   mem_wdata : write data, sequencer -> RAM
//   mem_rdata : synchronous read data, RAM -> sequencer
interface dm_bist_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dm_bist_seq.sv
// Memory BIST sequencer: writes a pattern to every RAM_B word, reads it back, counts mismatches.
// Latency: done rises 2*2^ADDR_W+1 edges after the edge that accepts start (129 for ADDR_W=6).
// Backpressure: none; start is ignored while busy, the RAM must take one access per cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start/pattern_sel : start level and pattern select (latched on accept)
//   mem               : RAM_B port bundle (master side)
//   busy/done/pass    : status; pass is valid while done=1
//   err_count, first_err_addr : mismatch statistics
//   disp_data         : word for the seven-segment display
module dm_bist_seq #(
    parameter int                ADDR_W = 6,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] SEED   = 32'h12345678
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          pattern_sel,
    dm_bist_seq_if.master       mem,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   disp_data
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [DATA_W-1:0] POLY = DATA_W'(32'h80200003);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [DATA_W-1:0]   lfsr, lfsr_n;
    logic [1:0]          pat_q, pat_n;
    logic [ADDR_W:0]     err_n;
    logic [ADDR_W-1:0]   fea_n;
    logic [DATA_W-1:0]   first_err_data, fed_n;
    logic [DATA_W-1:0]   disp_n;
    // Expected word and address of the read issued last cycle; compared
    // against mem_rdata this cycle because the RAM read is synchronous.
    logic                exp_vld, exp_vld_n;
    logic [DATA_W-1:0]   exp_dat, exp_dat_n;
    logic [ADDR_W-1:0]   exp_addr, exp_addr_n;
    logic [DATA_W-1:0]   cur_pat;
    logic [DATA_W-1:0]   lfsr_adv;
    logic                last_addr;
    logic                mismatch;

    assign lfsr_adv  = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
    assign last_addr = (addr == '1);
    assign mismatch  = exp_vld && (mem.mem_rdata != exp_dat);

    always_comb begin
        cur_pat = '0;
        case (pat_q)
            2'b00:   cur_pat = DATA_W'(32'h12345678);
            2'b01:   cur_pat = addr[0] ? DATA_W'(32'hAAAAAAAA) : DATA_W'(32'h55555555);
            2'b10:   cur_pat = DATA_W'(addr) ^ DATA_W'(32'hA5A5A5A5);
            default: cur_pat = lfsr;
        endcase
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        lfsr_n     = lfsr;
        pat_n      = pat_q;
        err_n      = err_count;
        fea_n      = first_err_addr;
        fed_n      = first_err_data;
        exp_vld_n  = 1'b0;
        exp_dat_n  = exp_dat;
        exp_addr_n = exp_addr;
        disp_n     = '0;

        if (mismatch) begin
            err_n = err_count + (ADDR_W+1)'(1);
            if (err_count == '0) begin
                fea_n = exp_addr;
                fed_n = mem.mem_rdata;
            end
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = WRITE;
                    pat_n   = pattern_sel;
                    err_n   = '0;
                    fea_n   = '0;
                    fed_n   = '0;
                    lfsr_n  = SEED;
                    addr_n  = '0;
                end
            end
            WRITE: begin
                addr_n = addr + ADDR_W'(1);
                lfsr_n = lfsr_adv;
                if (last_addr) begin
                    state_n = READ;
                    lfsr_n  = SEED;
                end
            end
            READ: begin
                exp_vld_n  = 1'b1;
                exp_dat_n  = cur_pat;
                exp_addr_n = addr;
                addr_n     = addr + ADDR_W'(1);
                lfsr_n     = lfsr_adv;
                if (last_addr) state_n = DRAIN;
            end
            DRAIN:   state_n = DONE;
            default: state_n = IDLE;
        endcase

        // Display is registered from next-state values so it tracks mem_addr
        // without a cycle of lag and shows the final result on entering DONE.
        case (state_n)
            WRITE, READ, DRAIN: disp_n = DATA_W'(addr_n);
            DONE:               disp_n = (err_n == '0) ? DATA_W'(32'h600D600D) : fed_n;
            default:            disp_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr           <= '0;
            lfsr           <= SEED;
            pat_q          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            exp_vld        <= 1'b0;
            exp_dat        <= '0;
            exp_addr       <= '0;
            disp_data      <= '0;
        end else begin
            state          <= state_n;
            addr           <= addr_n;
            lfsr           <= lfsr_n;
            pat_q          <= pat_n;
            err_count      <= err_n;
            first_err_addr <= fea_n;
            first_err_data <= fed_n;
            exp_vld        <= exp_vld_n;
            exp_dat        <= exp_dat_n;
            exp_addr       <= exp_addr_n;
            disp_data      <= disp_n;
        end
    end

    // Outputs decode directly from state so an asynchronous reset clears them at once.
    assign busy          = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign done          = (state == DONE);
    assign pass          = done && (err_count == '0);
    assign mem.mem_we    = (state == WRITE);
    assign mem.mem_addr  = busy ? addr : '0;
    assign mem.mem_wdata = (state == WRITE) ? cur_pat : '0;

endmodule

// File: tb/tb_dm_bist_seq.sv
module tb_dm_bist_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'b00;
    logic        busy, done, pass;
    logic [6:0]  err_count;
    logic [5:0]  first_err_addr;
    logic [31:0] disp_data;

    int tests = 0;
    int fails = 0;

    dm_bist_seq_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    dm_bist_seq #(.ADDR_W(6), .DATA_W(32), .SEED(32'h12345678)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pattern_sel    (pattern_sel),
        .mem            (bus.master),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .disp_data      (disp_data)
    );

    always #5 clk = ~clk;

    // RAM_B model: synchronous write and read, optional bit0 stuck-at-1 on address 5.
    logic [31:0] ram [64];
    bit          fault_en = 1'b0;
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr] | ((fault_en && bus.mem_addr == 6'd5) ? 32'h1 : 32'h0);
    end

    logic [31:0] wlog [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  pat;
        bit          fault;
        int          pulse_at;
        logic        pass;
        logic [6:0]  err;
        logic [5:0]  first;
        logic [31:0] disp;
        int          chk_addr;
        logic [31:0] chk_wdata;
    } vec_t;

    vec_t vecs [9];

    // Full run: start, follow every WRITE cycle, wait (bounded) for done, check results.
    task automatic run_vec(input vec_t v);
        int cycles;
        int wcnt;
        int seq_bad;
        fault_en = v.fault;
        @(negedge clk);
        pattern_sel = v.pat;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("first_write_addr", {26'b0, bus.mem_addr}, 32'd0);
        cycles = 0;
        wcnt = 0;
        seq_bad = 0;
        while (done !== 1'b1 && cycles < 400) begin
            if (bus.mem_we) begin
                if (bus.mem_addr != 6'(wcnt)) seq_bad++;
                wlog[bus.mem_addr] = bus.mem_wdata;
                wcnt++;
            end
            if (cycles == v.pulse_at) begin
                start = 1'b1;
                pattern_sel = 2'b01;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        chk("done_cycle", cycles, 32'd129);
        chk("write_count", wcnt, 32'd64);
        chk("write_seq_errors", seq_bad, 32'd0);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        chk("pass", {31'b0, pass}, {31'b0, v.pass});
        chk("err_count", {25'b0, err_count}, {25'b0, v.err});
        chk("first_err_addr", {26'b0, first_err_addr}, {26'b0, v.first});
        chk("disp_data", disp_data, v.disp);
        chk("wdata_at_addr", wlog[v.chk_addr], v.chk_wdata);
    endtask

    initial begin
        //         pat    flt  pulse pass err   first  disp           addr wdata
        vecs[0] = '{2'b00, 0, -1, 1'b1, 7'd0, 6'd0, 32'h600D600D, 0, 32'h12345678};
        vecs[1] = '{2'b11, 0, -1, 1'b1, 7'd0, 6'd0, 32'h600D600D, 0, 32'h12345678};
        vecs[2] = '{2'b11, 0, -1, 1'b1, 7'd0, 6'd0, 32'h600D600D, 1, 32'h091A2B3C};
        vecs[3] = '{2'b11, 0, -1, 1'b1, 7'd0, 6'd0, 32'h600D600D, 2, 32'h048D159E};
        vecs[4] = '{2'b10, 0, -1, 1'b1, 7'd0, 6'd0, 32'h600D600D, 3, 32'hA5A5A5A6};
        vecs[5] = '{2'b01, 0, -1, 1'b1, 7'd0, 6'd0, 32'h600D600D, 5, 32'hAAAAAAAA};
        vecs[6] = '{2'b01, 1, -1, 1'b0, 7'd1, 6'd5, 32'hAAAAAAAB, 5, 32'hAAAAAAAA};
        vecs[7] = '{2'b00, 0, -1, 1'b1, 7'd0, 6'd0, 32'h600D600D, 5, 32'h12345678};
        // Start pulse during WRITE must be ignored: pattern stays 00 at a late address.
        vecs[8] = '{2'b00, 0, 30, 1'b1, 7'd0, 6'd0, 32'h600D600D, 40, 32'h12345678};

        // Reset state.
        #12;
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", {26'b0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_busy_done_pass", {29'b0, busy, done, pass}, 32'd0);
        chk("rst_err_count", {25'b0, err_count}, 32'd0);
        chk("rst_disp", disp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_start", {30'b0, busy, done}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Fault with constant pattern: bit0 of 0x12345678 is 0, so the stuck bit is visible.
        run_vec('{2'b00, 1, -1, 1'b0, 7'd1, 6'd5, 32'h12345679, 5, 32'h12345678});

        // Asynchronous reset in the middle of WRITE.
        fault_en = 1'b0;
        @(negedge clk);
        pattern_sel = 2'b10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_addr_before_rst", {26'b0, bus.mem_addr}, 32'd20);
        chk("mid_we_before_rst", {31'b0, bus.mem_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_busy_done", {29'b0, bus.mem_we, busy, done}, 32'd0);
        chk("mid_rst_addr", {26'b0, bus.mem_addr}, 32'd0);
        chk("mid_rst_disp", disp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
